// File: rtl/ialu_mul_ctrl.sv
// ialu_mul_ctrl: shift-and-add multiply sequencer for the execute stage, stalls while running, then issues one write
//   ports: clock/reset (sync, active-high); in_act_ialu_mul request, in_flush abort, in_src1/in_src2 operands,
//   in_res_reg_idx destination; out_stall hold upstream, out_busy registered RUN|DONE, out_res low-half product,
//   out_act_write_res_to_reg one-cycle strobe, out_res_reg_idx destination of the result
module ialu_mul_ctrl #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH = 4,
  parameter int CNT_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_ialu_mul,
  input  logic                       in_flush,
  input  logic [IALU_WORD_WIDTH-1:0] in_src1,
  input  logic [IALU_WORD_WIDTH-1:0] in_src2,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                       out_stall,
  output logic                       out_busy,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic                       out_act_write_res_to_reg,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(IALU_WORD_WIDTH - 1);
  state_t state, state_nxt;
  logic [IALU_WORD_WIDTH-1:0] mcand, mplier, acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [REG_IDX_WIDTH-1:0] idx;
  logic start;
  assign start = (state == IDLE) & in_act_ialu_mul & ~in_flush;
  // DONE always returns to IDLE so the still-held request cannot retrigger
  always_comb
    state_nxt = in_flush ? IDLE :
                (state == IDLE) ? (start ? RUN : IDLE) :
                (state == RUN) ? ((cnt == LAST) ? DONE : RUN) : IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out_busy <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_nxt;
      out_busy <= state_nxt != IDLE;
      if (start) begin
        mcand <= in_src1;
        mplier <= in_src2;
        idx <= in_res_reg_idx;
        acc <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign out_stall = start | ((state == RUN) & ~in_flush);
  assign out_act_write_res_to_reg = (state == DONE) & ~in_flush;
  assign out_res = (state == DONE) ? acc : '0;
  assign out_res_reg_idx = (state == DONE) ? idx : '0;
endmodule

// File: tb/tb_ialu_mul_ctrl.sv
// tb_ialu_mul_ctrl: scoreboard bench for the multiply sequencer
module tb_ialu_mul_ctrl;
  logic clock = 0, reset = 1, in_act_ialu_mul = 0, in_flush = 0;
  logic [15:0] in_src1 = 0, in_src2 = 0;
  logic [3:0] in_res_reg_idx = 0;
  logic out_stall, out_busy, out_act_write_res_to_reg;
  logic [15:0] out_res;
  logic [3:0] out_res_reg_idx;
  int cyc = 0, n_checks = 0, n_fail = 0;
  typedef struct {logic [15:0] res; logic [3:0] idx; int cyc;} exp_t;
  exp_t sb[$];

  ialu_mul_ctrl dut (
    .clock(clock), .reset(reset), .in_act_ialu_mul(in_act_ialu_mul), .in_flush(in_flush),
    .in_src1(in_src1), .in_src2(in_src2), .in_res_reg_idx(in_res_reg_idx),
    .out_stall(out_stall), .out_busy(out_busy), .out_res(out_res),
    .out_act_write_res_to_reg(out_act_write_res_to_reg), .out_res_reg_idx(out_res_reg_idx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (out_act_write_res_to_reg) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write cyc=%0d res=%h idx=%0d, required no write", cyc, out_res, out_res_reg_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_res !== e.res || out_res_reg_idx !== e.idx || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL write_result got res=%h idx=%0d cyc=%0d, required res=%h idx=%0d cyc=%0d",
                   out_res, out_res_reg_idx, cyc, e.res, e.idx, e.cyc);
        end
      end
    end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    next_cycle();
    next_cycle();
    @(negedge clock);
    n_checks++;
    if ({out_stall, out_busy, out_act_write_res_to_reg, out_res, out_res_reg_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got stall=%b busy=%b wr=%b res=%h idx=%0d, required all 0",
               out_stall, out_busy, out_act_write_res_to_reg, out_res, out_res_reg_idx);
    end
    reset = 0;
    next_cycle();
    @(negedge clock);
    n_checks++;
    if ({out_stall, out_busy, out_res, out_res_reg_idx} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs got stall=%b busy=%b res=%h idx=%0d, required all 0",
               out_stall, out_busy, out_res, out_res_reg_idx);
    end
  endtask

  task automatic test_multiply(input logic [15:0] a, input logic [15:0] b, input logic [3:0] i);
    logic [15:0] p;
    p = a * b;
    next_cycle();
    in_act_ialu_mul = 1; in_src1 = a; in_src2 = b; in_res_reg_idx = i;
    sb.push_back('{p, i, cyc + 17});
    for (int k = 0; k <= 17; k++) begin
      @(negedge clock);
      n_checks++;
      if (out_stall !== (k <= 16) || out_busy !== (k >= 1)) begin
        n_fail++;
        $display("FAIL mul_timing k=%0d got stall=%b busy=%b, required stall=%b busy=%b",
                 k, out_stall, out_busy, k <= 16, k >= 1);
      end
      if (k == 1) begin in_src1 = ~a; in_src2 = ~b; in_res_reg_idx = ~i; end
      next_cycle();
    end
    in_act_ialu_mul = 0;
    @(negedge clock);
    n_checks++;
    if (out_stall !== 0 || out_busy !== 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL mul_idle got stall=%b busy=%b pending=%0d, required 0 0 0", out_stall, out_busy, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    in_act_ialu_mul = 1; in_src1 = 16'd9; in_src2 = 16'd11; in_res_reg_idx = 4'd1;
    sb.push_back('{16'd99, 4'd1, cyc + 17});
    for (int k = 0; k <= 35; k++) begin
      if (k == 18) begin
        in_src1 = 16'd7; in_src2 = 16'd6; in_res_reg_idx = 4'd2;
        sb.push_back('{16'h002A, 4'd2, cyc + 17});
      end
      @(negedge clock);
      n_checks++;
      if (out_stall !== (k != 17 && k != 35)) begin
        n_fail++;
        $display("FAIL b2b_stall k=%0d got %b, required %b", k, out_stall, k != 17 && k != 35);
      end
      next_cycle();
    end
    in_act_ialu_mul = 0;
    @(negedge clock);
    n_checks++;
    if (sb.size() != 0 || out_busy !== 0) begin
      n_fail++;
      $display("FAIL b2b_done got pending=%0d busy=%b, required 0 0", sb.size(), out_busy);
    end
  endtask

  task automatic test_flush();
    next_cycle();
    in_act_ialu_mul = 1; in_src1 = 16'd3; in_src2 = 16'd5; in_res_reg_idx = 4'd3;
    for (int k = 0; k < 5; k++) next_cycle();
    in_flush = 1;
    @(negedge clock);
    n_checks++;
    if (out_stall !== 0 || out_busy !== 1) begin
      n_fail++;
      $display("FAIL flush_cycle got stall=%b busy=%b, required 0 1", out_stall, out_busy);
    end
    next_cycle();
    in_flush = 0; in_act_ialu_mul = 0;
    @(negedge clock);
    n_checks++;
    if (out_busy !== 0 || out_stall !== 0) begin
      n_fail++;
      $display("FAIL flush_idle got busy=%b stall=%b, required 0 0", out_busy, out_stall);
    end
    for (int k = 0; k < 20; k++) next_cycle();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    in_act_ialu_mul = 1; in_src1 = 16'd12; in_src2 = 16'd12; in_res_reg_idx = 4'd5;
    for (int k = 0; k < 9; k++) next_cycle();
    reset = 1; in_act_ialu_mul = 0;
    next_cycle();
    reset = 0;
    @(negedge clock);
    n_checks++;
    if ({out_stall, out_busy, out_act_write_res_to_reg, out_res, out_res_reg_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got stall=%b busy=%b wr=%b res=%h idx=%0d, required all 0",
               out_stall, out_busy, out_act_write_res_to_reg, out_res, out_res_reg_idx);
    end
    for (int k = 0; k < 20; k++) next_cycle();
  endtask

  task automatic test_flush_idle();
    next_cycle();
    in_act_ialu_mul = 1; in_flush = 1; in_src1 = 16'd4; in_src2 = 16'd4;
    @(negedge clock);
    n_checks++;
    if (out_stall !== 0) begin
      n_fail++;
      $display("FAIL flush_idle_stall got %b, required 0", out_stall);
    end
    next_cycle();
    in_act_ialu_mul = 0; in_flush = 0;
    @(negedge clock);
    n_checks++;
    if (out_busy !== 0 || out_stall !== 0) begin
      n_fail++;
      $display("FAIL flush_idle_state got busy=%b stall=%b, required 0 0", out_busy, out_stall);
    end
    for (int k = 0; k < 20; k++) next_cycle();
  endtask

  initial begin
    test_reset();
    test_multiply(16'd3, 16'd5, 4'd7);
    test_multiply(16'hFFFF, 16'hFFFF, 4'd9);
    test_multiply(16'h0100, 16'h0100, 4'd15);
    test_multiply(16'h1234, 16'h00AB, 4'd4);
    test_back_to_back();
    test_flush();
    test_multiply(16'd13, 16'd21, 4'd6);
    test_reset_mid();
    test_flush_idle();
    next_cycle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes got %0d, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ialu_mul_ctrl.md
Name: ialu_mul_ctrl

Overview:
- Sequencer for a multi-cycle integer multiply in the execute stage.
- Reuses one adder iteratively: shift-and-add, one partial product per cycle.
- Holds the pipeline with a stall while running, then issues a one-cycle register-write result.
- Sits beside the exec ALU. Takes the same decoded sources and destination index, and obeys the exec-stage flush.

Parameters:
IALU_WORD_WIDTH, 16, operand/result width
REG_IDX_WIDTH, 4, register index width
CNT_WIDTH, 5, iteration counter width (must hold IALU_WORD_WIDTH-1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_act_ialu_mul  input  1  decoded multiply request (held high while stalled)
in_flush  input  1  exec-stage flush (taken jump); aborts operation
in_src1  input  IALU_WORD_WIDTH  multiplicand
in_src2  input  IALU_WORD_WIDTH  multiplier
in_res_reg_idx  input  REG_IDX_WIDTH  destination register index
out_stall  output  1  hold upstream stages
out_busy  output  1  registered; high in RUN and DONE
out_res  output  IALU_WORD_WIDTH  product, low IALU_WORD_WIDTH bits
out_act_write_res_to_reg  output  1  one-cycle write strobe
out_res_reg_idx  output  REG_IDX_WIDTH  destination index of result

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All state updates on the posedge of clock.
- Reset: state=IDLE; counter, accumulator, operand and index registers = 0. All outputs 0 in the cycle after reset. A reset asserted mid-operation discards the operation with no write.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start = in_act_ialu_mul & !in_flush.
  - On start: latch mcand=in_src1, mplier=in_src2, idx=in_res_reg_idx; acc=0; cnt=0; go to RUN.
  - out_stall = start (combinational). The requesting instruction is held in the start cycle.
- RUN, each cycle:
  - If mplier[0]: acc <= acc + mcand, modulo 2^IALU_WORD_WIDTH.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == IALU_WORD_WIDTH-1, go to DONE.
  - Fixed 16 iterations, no early exit. out_stall = 1.
- DONE:
  - out_act_write_res_to_reg = 1, out_res = acc, out_res_reg_idx = idx, out_stall = 0.
  - Next state is IDLE unconditionally.
  - in_act_ialu_mul is still high here (same instruction); it is ignored and must not retrigger.
- Latency: start at cycle T, RUN T+1..T+16, DONE (write strobe) at T+17, IDLE at T+18.
- Outside DONE: out_res=0, out_act_write_res_to_reg=0, out_res_reg_idx=0.
- Flush:
  - in_flush in RUN or DONE: next state IDLE, no write strobe in that cycle; out_stall=0 combinationally in the flush cycle.
  - in_flush together with a request in IDLE: request ignored.
- Width: product truncated to the low IALU_WORD_WIDTH bits; unsigned and two's-complement low halves are identical.
- Only one operation in flight; no queueing.

Test Plan:
- Reset, then src1=3, src2=5, request at T -> stall high T..T+16, write strobe at T+17 with out_res=0x000F, idx echoed, IDLE at T+18.
- src1=0xFFFF, src2=0xFFFF -> out_res=0x0001 at T+17; src1=0x0100, src2=0x0100 -> out_res=0x0000 (overflow truncated).
- Request held high through DONE, new request (7*6, idx=2) presented at T+18 -> exactly one write at T+17 for the first op, second write at T+35 with 0x002A.
- in_flush pulsed at T+5 -> stall drops at T+5, no write strobe ever, IDLE at T+6; a following request starts normally.
- reset asserted at T+9 -> all outputs 0 from T+10, no write strobe; request and flush together in IDLE -> no stall, stays IDLE.
